// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: drives a variable-latency instruction memory with at
// most one outstanding request, owns the IF/ID register, parks a fetched word in
// a one-entry hold buffer while decode is frozen, and lets a wrong-path fetch
// that is still in flight complete (and be dropped) before redirecting.
module if_fetch_stage #(
    parameter int                  WORD_LEN = 32,
    parameter logic [WORD_LEN-1:0] RESET_PC = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                freeze,
    input  logic                brTaken,
    input  logic [WORD_LEN-1:0] brOffset,
    output logic                imem_req,
    output logic [WORD_LEN-1:0] imem_addr,
    input  logic                imem_ack,
    input  logic [WORD_LEN-1:0] imem_rdata,
    output logic [WORD_LEN-1:0] PC_out,
    output logic [WORD_LEN-1:0] instruction,
    output logic                valid
);

    typedef enum logic [1:0] {
        FETCH   = 2'd0,
        HOLD    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    // Word offset scaled to bytes and added to the IF/ID return address; wraps.
    function automatic logic [WORD_LEN-1:0] branch_target(
        input logic        [WORD_LEN-1:0] base,
        input logic signed [WORD_LEN-1:0] off_words
    );
        logic signed [WORD_LEN-1:0] off_bytes;
        off_bytes = off_words <<< 2;
        return base + $unsigned(off_bytes);
    endfunction

    state_t              state_q, state_nxt;

    // Fetch side (p0): PC, hold buffer, stale (in-flight wrong-path) address
    logic [WORD_LEN-1:0] pc_p0, pc_nxt;
    logic [WORD_LEN-1:0] hold_word_p0, hold_word_nxt;
    logic [WORD_LEN-1:0] hold_pc4_p0, hold_pc4_nxt;
    logic [WORD_LEN-1:0] stale_addr_p0, stale_addr_nxt;

    // IF/ID boundary (p1)
    logic [WORD_LEN-1:0] pc_out_p1, pc_out_nxt;
    logic [WORD_LEN-1:0] instr_p1, instr_nxt;
    logic                vld_p1, vld_nxt;

    logic [WORD_LEN-1:0] pc_plus4;
    logic [WORD_LEN-1:0] br_target;
    logic                take_br;

    assign pc_plus4  = pc_p0 + WORD_LEN'(4);
    assign br_target = branch_target(pc_out_p1, brOffset);
    assign take_br   = brTaken && !freeze;

    assign imem_req    = !rst && (state_q != HOLD);
    assign imem_addr   = (state_q == DISCARD) ? stale_addr_p0 : pc_p0;
    assign PC_out      = pc_out_p1;
    assign instruction = instr_p1;
    assign valid       = vld_p1;

    // Next-state and register updates; freeze always wins over a branch.
    always_comb begin
        state_nxt      = state_q;
        pc_nxt         = pc_p0;
        hold_word_nxt  = hold_word_p0;
        hold_pc4_nxt   = hold_pc4_p0;
        stale_addr_nxt = stale_addr_p0;
        pc_out_nxt     = pc_out_p1;
        instr_nxt      = instr_p1;
        vld_nxt        = vld_p1;

        case (state_q)
            FETCH: begin
                if (imem_ack) begin
                    if (freeze) begin
                        hold_word_nxt = imem_rdata;
                        hold_pc4_nxt  = pc_plus4;
                        pc_nxt        = pc_plus4;
                        state_nxt     = HOLD;
                    end else if (brTaken) begin
                        pc_nxt     = br_target;
                        pc_out_nxt = '0;
                        instr_nxt  = '0;
                        vld_nxt    = 1'b0;
                    end else begin
                        pc_out_nxt = pc_plus4;
                        instr_nxt  = imem_rdata;
                        vld_nxt    = 1'b1;
                        pc_nxt     = pc_plus4;
                    end
                end else if (take_br) begin
                    // The request at pc_p0 is still owed an ack; remember it.
                    stale_addr_nxt = pc_p0;
                    pc_nxt         = br_target;
                    pc_out_nxt     = '0;
                    instr_nxt      = '0;
                    vld_nxt        = 1'b0;
                    state_nxt      = DISCARD;
                end else if (!freeze) begin
                    instr_nxt = '0;
                    vld_nxt   = 1'b0;
                end
            end

            HOLD: begin
                if (!freeze) begin
                    if (brTaken) begin
                        pc_nxt     = br_target;
                        pc_out_nxt = '0;
                        instr_nxt  = '0;
                        vld_nxt    = 1'b0;
                    end else begin
                        pc_out_nxt = hold_pc4_p0;
                        instr_nxt  = hold_word_p0;
                        vld_nxt    = 1'b1;
                    end
                    state_nxt = FETCH;
                end
            end

            DISCARD: begin
                if (imem_ack) begin
                    state_nxt = FETCH;
                end
                if (take_br) begin
                    pc_nxt     = br_target;
                    pc_out_nxt = '0;
                    instr_nxt  = '0;
                    vld_nxt    = 1'b0;
                end
            end

            default: begin
                state_nxt = FETCH;
            end
        endcase
    end

    // State, fetch-side and IF/ID registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= FETCH;
            pc_p0         <= RESET_PC;
            hold_word_p0  <= '0;
            hold_pc4_p0   <= '0;
            stale_addr_p0 <= '0;
            pc_out_p1     <= '0;
            instr_p1      <= '0;
            vld_p1        <= 1'b0;
        end else begin
            state_q       <= state_nxt;
            pc_p0         <= pc_nxt;
            hold_word_p0  <= hold_word_nxt;
            hold_pc4_p0   <= hold_pc4_nxt;
            stale_addr_p0 <= stale_addr_nxt;
            pc_out_p1     <= pc_out_nxt;
            instr_p1      <= instr_nxt;
            vld_p1        <= vld_nxt;
        end
    end

endmodule

// File: doc/if_fetch_stage.md
IF_FETCH_STAGE -- requirements
Module: if_fetch_stage

Interface
REQ-001 Parameter WORD_LEN, default 32, sets the data/address width.
REQ-002 Parameter RESET_PC, default 32'h0000_0000, sets the first fetch address.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 freeze  input  1  hazard stall from the decode stage; hold the IF/ID outputs.
REQ-006 brTaken  input  1  decode stage resolved a taken branch for the instruction currently in IF/ID.
REQ-007 brOffset  input  WORD_LEN  sign-extended 16-bit branch immediate from the decode stage, in words.
REQ-008 imem_req  output  1  fetch request to instruction memory.
REQ-009 imem_addr  output  WORD_LEN  byte address of the outstanding fetch.
REQ-010 imem_ack  input  1  memory returns imem_rdata this cycle; variable latency, minimum 0 cycles (same-cycle ack allowed).
REQ-011 imem_rdata  input  WORD_LEN  fetched instruction word, valid only when imem_ack is 1.
REQ-012 PC_out  output  WORD_LEN  address+4 of the instruction held in IF/ID.
REQ-013 instruction  output  WORD_LEN  IF/ID instruction register.
REQ-014 valid  output  1  IF/ID holds a real instruction (0 = bubble).

Function
REQ-015 Internal state: PC register; IF/ID register {PC_out, instruction, valid}; hold buffer {word, PC+4}; stale-address register; FSM with states FETCH, HOLD, DISCARD.
REQ-016 imem_req = 1 in FETCH and DISCARD, 0 in HOLD; imem_addr = PC in FETCH, stale address in DISCARD; imem_addr is stable while imem_req=1 and imem_ack=0.
REQ-017 Branch target = PC_out + (brOffset << 2), modulo 2^WORD_LEN; PC+4 also wraps modulo 2^WORD_LEN.
REQ-018 freeze has priority over brTaken; brTaken is ignored in any cycle with freeze=1.
REQ-019 Flush = IF/ID set to {0, 0, valid=0} on the next edge.
REQ-020 FETCH, ack, brTaken: drop the word, PC <= target, flush, stay in FETCH.
REQ-021 FETCH, ack, freeze: hold buffer <= {imem_rdata, PC+4}, PC <= PC+4, IF/ID unchanged, go to HOLD.
REQ-022 FETCH, ack, neither: IF/ID <= {PC+4, imem_rdata, 1}, PC <= PC+4, stay in FETCH; one instruction per cycle when ack is continuous.
REQ-023 FETCH, no ack, brTaken: stale <= PC, PC <= target, flush, go to DISCARD.
REQ-024 FETCH, no ack, freeze: nothing changes. FETCH, no ack, neither: IF/ID <= bubble (instruction=0, valid=0, PC_out unchanged).
REQ-025 HOLD, freeze: no change. HOLD, brTaken: discard the buffer, PC <= target, flush, go to FETCH. HOLD, neither: IF/ID <= {buffer PC+4, buffer word, 1}, go to FETCH.
REQ-026 DISCARD, ack: drop the word, go to FETCH. Independently, brTaken in DISCARD sets PC <= target and flushes; state follows ack. freeze in DISCARD: IF/ID and PC hold.
REQ-027 At most one outstanding request exists; the block never issues a new address before the prior one is acked.

Reset
REQ-028 While rst=1: PC=RESET_PC, state=FETCH, IF/ID={0,0,0}, buffer=0, stale=0, imem_req=0.
REQ-029 First request (imem_addr=RESET_PC) is asserted in the first cycle after rst deasserts; rst mid-transaction abandons any pending ack; an ack arriving in the first cycle after reset completes that new request.

Verification
REQ-030 Reset, then ack every cycle, rdata=A,B,C -> IF/ID shows (4,A,1),(8,B,1),(12,C,1) on consecutive cycles; imem_addr 0,4,8.
REQ-031 Ack delayed 3 cycles at addr 4 -> imem_addr held at 4 for all 4 cycles, valid=0 for the 3 waiting cycles, then (8,word,1).
REQ-032 freeze=1 for 2 cycles coinciding with ack of addr 8 -> IF/ID holds (8,B,1), imem_req=0 in HOLD; after release IF/ID=(12,C,1), next imem_addr=12.
REQ-033 IF/ID PC_out=8, brTaken=1, brOffset=3, no ack pending -> DISCARD: imem_addr stays old address until ack, IF/ID flushed, then imem_addr=20.
REQ-034 brTaken=1 and freeze=1 together -> branch ignored, PC and IF/ID unchanged.
REQ-035 PC_out=4, brOffset=32'hFFFF_FFFE, brTaken=1 -> next fetch address 32'hFFFF_FFFC (wrap).
